// File: rtl/rv32_pkg.sv
// RV32I shared decode definitions.
// Opcodes, immediate formats and the ID/EX bundle.
package rv32_pkg;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_type_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [RA_W-1:0] rd;
      logic            rd_we;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic            illegal;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
   } id_ex_t;

   // Full 7-bit compare also rejects compressed (instr[1:0] != 2'b11)
   function automatic logic opc_legal(input logic [6:0] opc);
      logic ok;
      ok = 1'b0;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
         OPC_BRANCH, OPC_LOAD, OPC_STORE,
         OPC_OP_IMM, OPC_OP, OPC_FENCE,
         OPC_SYSTEM: ok = 1'b1;
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// RV32I immediate generator.
// Pure combinational: format select plus sign extension.
module imm_gen
   import rv32_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm,
   output imm_type_t   imm_type
);

   always_comb begin
      imm_type = IMM_NONE;
      case (instr[6:0])
         OPC_LOAD,
         OPC_OP_IMM,
         OPC_JALR,
         OPC_SYSTEM: imm_type = IMM_I;
         OPC_STORE:  imm_type = IMM_S;
         OPC_BRANCH: imm_type = IMM_B;
         OPC_LUI,
         OPC_AUIPC:  imm_type = IMM_U;
         OPC_JAL:    imm_type = IMM_J;
         default:    imm_type = IMM_NONE;
      endcase
   end

   always_comb begin
      imm = '0;
      case (imm_type)
         IMM_I: imm = {{20{instr[31]}},
                       instr[31:20]};
         IMM_S: imm = {{20{instr[31]}},
                       instr[31:25],
                       instr[11:7]};
         IMM_B: imm = {{19{instr[31]}},
                       instr[31],
                       instr[7],
                       instr[30:25],
                       instr[11:8],
                       1'b0};
         IMM_U: imm = {instr[31:12],
                       12'b0};
         IMM_J: imm = {{11{instr[31]}},
                       instr[31],
                       instr[19:12],
                       instr[20],
                       instr[30:21],
                       1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage with writeback bypass.
// Single ID/EX slot, valid/ready on both sides.
module id_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic [RA_W-1:0] rf_raddr1,
   output logic [RA_W-1:0] rf_raddr2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic            wb_we,
   input  logic [RA_W-1:0] wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic [RA_W-1:0] out_rd,
   output logic            out_rd_we,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic            out_illegal
);

   import rv32_pkg::*;

   logic        valid_q, valid_d;
   id_ex_t      slot_q, slot_d;
   logic        cap;
   logic        legal;
   logic        rd_we;
   logic        wb_hit;
   logic [31:0] imm;
   imm_type_t   imm_type;

   imm_gen u_imm_gen (
      .instr    (in_instr),
      .imm      (imm),
      .imm_type (imm_type)
   );

   assign rf_raddr1 = in_instr[19:15];
   assign rf_raddr2 = in_instr[24:20];

   assign in_ready = !valid_q || out_ready;
   assign cap      = in_valid && in_ready && !flush;
   assign wb_hit   = wb_we && (wb_addr != '0);

   assign legal = opc_legal(in_instr[6:0]);
   assign rd_we = legal
               && (imm_type != IMM_S)
               && (imm_type != IMM_B)
               && (in_instr[6:0] != OPC_FENCE)
               && (in_instr[11:7] != '0);

   always_comb begin
      if (flush)
         valid_d = 1'b0;
      else if (cap)
         valid_d = 1'b1;
      else if (out_ready)
         valid_d = 1'b0;
      else
         valid_d = valid_q;
   end

   // RF write lands on this same edge, so its read data is stale
   always_comb begin
      slot_d = slot_q;
      if (cap) begin
         slot_d.pc      = in_pc;
         slot_d.imm     = imm;
         slot_d.rd      = in_instr[11:7];
         slot_d.rd_we   = rd_we;
         slot_d.opcode  = in_instr[6:0];
         slot_d.funct3  = in_instr[14:12];
         slot_d.funct7  = in_instr[31:25];
         slot_d.illegal = !legal;
         slot_d.rs1     = rf_raddr1;
         slot_d.rs2     = rf_raddr2;
         slot_d.rs1_data =
            (wb_hit && wb_addr == rf_raddr1)
            ? wb_data : rf_rdata1;
         slot_d.rs2_data =
            (wb_hit && wb_addr == rf_raddr2)
            ? wb_data : rf_rdata2;
      end else if (valid_q) begin
         if (wb_hit && wb_addr == slot_q.rs1)
            slot_d.rs1_data = wb_data;
         if (wb_hit && wb_addr == slot_q.rs2)
            slot_d.rs2_data = wb_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         slot_q  <= '0;
      end else begin
         valid_q <= valid_d;
         slot_q  <= slot_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = slot_q.pc;
   assign out_rs1_data = slot_q.rs1_data;
   assign out_rs2_data = slot_q.rs2_data;
   assign out_imm      = slot_q.imm;
   assign out_rd       = slot_q.rd;
   assign out_rd_we    = slot_q.rd_we;
   assign out_opcode   = slot_q.opcode;
   assign out_funct3   = slot_q.funct3;
   assign out_funct7   = slot_q.funct7;
   assign out_illegal  = slot_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage.
// The bench owns the register file and a spec-level slot model.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic [6:0]  out_opcode, out_funct7;
   logic [2:0]  out_funct3;
   logic        out_illegal;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] regs [32];

   typedef struct {
      logic        valid;
      logic [31:0] pc, rs1_data, rs2_data, imm;
      logic [4:0]  rd, rs1, rs2;
      logic        rd_we, illegal;
      logic [6:0]  opcode, funct7;
      logic [2:0]  funct3;
   } exp_t;

   exp_t e;

   always #5 clk = ~clk;

   assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : regs[rf_raddr1];
   assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : regs[rf_raddr2];

   id_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .rf_raddr1    (rf_raddr1),
      .rf_raddr2    (rf_raddr2),
      .rf_rdata1    (rf_rdata1),
      .rf_rdata2    (rf_rdata2),
      .wb_we        (wb_we),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_rs1_data (out_rs1_data),
      .out_rs2_data (out_rs2_data),
      .out_imm      (out_imm),
      .out_rd       (out_rd),
      .out_rd_we    (out_rd_we),
      .out_opcode   (out_opcode),
      .out_funct3   (out_funct3),
      .out_funct7   (out_funct7),
      .out_illegal  (out_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference decode, written from the encoding tables
   function automatic bit is_legal(input logic [6:0] o);
      return o inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                       7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] i);
      int v;
      v = 0;
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h73: v = $signed(i) >>> 20;
         7'h23: v = (($signed(i) >>> 20) & ~31) | int'(i[11:7]);
         7'h63: begin
            v = i[31] ? -4096 : 0;
            v += int'(i[7]) * 2048;
            v += int'(i[30:25]) * 32;
            v += int'(i[11:8]) * 2;
         end
         7'h37, 7'h17: v = int'(i & 32'hFFFF_F000);
         7'h6F: begin
            v = i[31] ? -(1 << 20) : 0;
            v += int'(i[19:12]) * 4096;
            v += int'(i[20]) * 2048;
            v += int'(i[30:21]) * 2;
         end
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   function automatic bit ref_rd_we(input logic [31:0] i);
      return is_legal(i[6:0]) && (i[11:7] != 0)
          && !(i[6:0] inside {7'h63, 7'h23, 7'h0F});
   endfunction

   function automatic logic [31:0] rf_rd(input logic [4:0] a);
      return (a == 0) ? 32'd0 : regs[a];
   endfunction

   task automatic model_reset();
      e = '{default: '0};
   endtask

   task automatic check_out();
      chk("out_valid", 32'(out_valid), 32'(e.valid));
      if (e.valid) begin
         chk("out_pc", out_pc, e.pc);
         chk("out_rs1_data", out_rs1_data, e.rs1_data);
         chk("out_rs2_data", out_rs2_data, e.rs2_data);
         chk("out_imm", out_imm, e.imm);
         chk("out_rd", 32'(out_rd), 32'(e.rd));
         chk("out_rd_we", 32'(out_rd_we), 32'(e.rd_we));
         chk("out_opcode", 32'(out_opcode), 32'(e.opcode));
         chk("out_funct3", 32'(out_funct3), 32'(e.funct3));
         chk("out_funct7", 32'(out_funct7), 32'(e.funct7));
         chk("out_illegal", 32'(out_illegal), 32'(e.illegal));
      end
   endtask

   task automatic step();
      exp_t n;
      bit   acc, hit;
      #1;
      chk("in_ready", 32'(in_ready), 32'(!e.valid || out_ready));
      chk("rf_raddr1", 32'(rf_raddr1), 32'(in_instr[19:15]));
      chk("rf_raddr2", 32'(rf_raddr2), 32'(in_instr[24:20]));
      n   = e;
      acc = in_valid && (!e.valid || out_ready) && !flush;
      hit = wb_we && wb_addr != 0;
      n.valid = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : e.valid;
      if (acc) begin
         n.pc      = in_pc;
         n.rs1     = in_instr[19:15];
         n.rs2     = in_instr[24:20];
         n.rs1_data = (hit && wb_addr == n.rs1) ? wb_data : rf_rd(n.rs1);
         n.rs2_data = (hit && wb_addr == n.rs2) ? wb_data : rf_rd(n.rs2);
         n.imm     = ref_imm(in_instr);
         n.rd      = in_instr[11:7];
         n.rd_we   = ref_rd_we(in_instr);
         n.opcode  = in_instr[6:0];
         n.funct3  = in_instr[14:12];
         n.funct7  = in_instr[31:25];
         n.illegal = !is_legal(in_instr[6:0]);
      end else if (e.valid) begin
         if (hit && wb_addr == e.rs1) n.rs1_data = wb_data;
         if (hit && wb_addr == e.rs2) n.rs2_data = wb_data;
      end
      @(posedge clk);
      #1;
      if (hit) regs[wb_addr] = wb_data;
      e = n;
      check_out();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  opcs [12];
      opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
               7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
      w = $urandom;
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) != 0)
         w[6:0] = opcs[$urandom_range(0, 11)];
      return w;
   endfunction

   task automatic idle_in();
      in_valid = 0;
      wb_we    = 0;
      wb_addr  = 0;
      wb_data  = 0;
      flush    = 0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 0 : $urandom;
      regs[1]   = 32'd10;
      rst       = 1;
      in_instr  = 0;
      in_pc     = 0;
      out_ready = 1;
      idle_in();
      model_reset();
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_rs1", out_rs1_data, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      #1;
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);

      // ADDI x5,x1,-3
      in_valid = 1;
      in_instr = 32'hFFD0_8293;
      in_pc    = 32'h100;
      step();
      chk("addi_rs1", out_rs1_data, 32'd10);
      chk("addi_imm", out_imm, 32'hFFFF_FFFD);
      chk("addi_rd", 32'(out_rd), 32'd5);
      chk("addi_rd_we", 32'(out_rd_we), 32'd1);

      // Bypass at capture, then x0 never bypasses
      wb_we   = 1;
      wb_addr = 1;
      wb_data = 32'h55;
      in_pc   = 32'h104;
      step();
      chk("bypass_rs1", out_rs1_data, 32'h55);
      wb_addr = 0;
      wb_data = 32'h99;
      in_pc   = 32'h108;
      step();
      chk("bypass_x0", out_rs1_data, 32'h55);

      // ADD x3,x1,x2 then stall 3 cycles with a rs2 write
      wb_we    = 0;
      in_instr = 32'h0020_81B3;
      in_pc    = 32'h10C;
      step();
      out_ready = 0;
      in_instr  = 32'h0000_0013;
      in_pc     = 32'h110;
      step();
      wb_we   = 1;
      wb_addr = 2;
      wb_data = 32'hAB;
      step();
      wb_we = 0;
      step();
      chk("stall_rs2", out_rs2_data, 32'hAB);
      chk("stall_pc", out_pc, 32'h10C);
      out_ready = 1;

      // BEQ -8, JAL +2048, all-zero word
      in_instr = 32'hFE00_0CE3;
      in_pc    = 32'h200;
      step();
      chk("beq_imm", out_imm, 32'hFFFF_FFF8);
      chk("beq_rd_we", 32'(out_rd_we), 32'd0);
      in_instr = 32'h0010_00EF;
      step();
      chk("jal_imm", out_imm, 32'h0000_0800);
      in_instr = 32'h0;
      step();
      chk("zero_illegal", 32'(out_illegal), 32'd1);

      // Flush kills the same-cycle acceptance
      in_instr = 32'h0050_0313;
      flush    = 1;
      step();
      chk("flush_valid", 32'(out_valid), 32'd0);
      flush = 0;
      in_pc = 32'h300;
      step();
      chk("post_flush_valid", 32'(out_valid), 32'd1);

      // Reset while stalled
      out_ready = 0;
      in_valid  = 1;
      in_instr  = 32'h0041_8193;
      step();
      rst = 1;
      #1;
      model_reset();
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_imm", out_imm, 32'd0);
      @(posedge clk);
      #1;
      rst = 0;
      out_ready = 1;
      idle_in();
      step();

      for (int k = 0; k < 400; k++) begin
         in_valid  = $urandom_range(0, 3) != 0;
         in_instr  = rand_instr();
         in_pc     = $urandom & 32'hFFFF_FFFC;
         out_ready = $urandom_range(0, 2) != 0;
         wb_we     = $urandom_range(0, 1) != 0;
         wb_addr   = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         flush     = $urandom_range(0, 15) == 0;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
